// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit scheduler and the TX/RX instances.
// The frame and packet constants must match the TX/RX parameters used in the same top level.
package uart_pkg;

  localparam int UART_FRAME_CYCLES = 11;
  localparam int UART_PACKET       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N.
// The grant is gated by en; idx and any reflect the requests regardless of en.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int   pos;
    logic found;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

  assign any = |req;

  always_comb begin
    grant = '0;
    if (en && any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte producers with round-robin selection.
// state | meaning
// IDLE  | ready offered to the round-robin winner; accept loads tx_data and fires tx_start
// SEND  | transmitter occupied for FRAME_CYCLES; tx_done fires as the window closes
// GAP   | forced idle-high spacing of GAP_CYCLES before the next accept
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int PACKET       = UART_PACKET,
  parameter  int FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter  int GAP_CYCLES   = 1,
  localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W        = $clog2(((FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*PACKET-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [PACKET-1:0]       tx_data,
  output logic                    tx_start,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    tx_done,
  output logic [ID_W-1:0]         done_id
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  // Unreachable when GAP_CYCLES is 0, since SEND then returns straight to IDLE.
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  sched_state_t      state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              in_idle;
  logic [PACKET-1:0] sel_data;
  logic [ID_W-1:0]   ptr_next;

  assign in_idle = (state == IDLE);

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (in_idle),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign req_ready = arb_grant;

  always_comb begin
    sel_data = req_data[int'(arb_idx)*PACKET +: PACKET];
  end

  assign ptr_next = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      done_id  <= '0;
    end else begin
      tx_start <= 1'b0;
      tx_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            tx_data  <= sel_data;
            tx_start <= 1'b1;
            grant_id <= arb_idx;
            busy     <= 1'b1;
            cnt      <= '0;
            rr_ptr   <= ptr_next;
            state    <= SEND;
          end
        end
        SEND: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == FRAME_LAST) begin
            tx_done <= 1'b1;
            done_id <= grant_id;
            cnt     <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a frame-timing reference model,
// plus a second instance with no inter-frame gap.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N    = 4;
  localparam int P    = 8;
  localparam int F    = 11;
  localparam int G    = 1;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*P-1:0]  req_data;
  logic [P-1:0]    tx_data;
  logic            tx_start, busy, tx_done;
  logic [ID_W-1:0] grant_id, done_id;

  logic [N-1:0]    req_valid2, req_ready2;
  logic [N*P-1:0]  req_data2;
  logic [P-1:0]    tx_data2;
  logic            tx_start2, busy2, tx_done2;
  logic [ID_W-1:0] grant_id2, done_id2;

  uart_tx_sched #(.N_REQ(N), .PACKET(P), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .grant_id(grant_id), .busy(busy),
    .tx_done(tx_done), .done_id(done_id)
  );

  uart_tx_sched #(.N_REQ(N), .PACKET(P), .FRAME_CYCLES(F), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .tx_data(tx_data2), .tx_start(tx_start2), .grant_id(grant_id2), .busy(busy2),
    .tx_done(tx_done2), .done_id(done_id2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one frame at a time, timed from the accept cycle.
  int cyc, next_free, acc_cyc, acc_id, exp_done_id, rr_m, n_accepts;
  logic [P-1:0] acc_data;
  logic [N-1:0] pend;
  logic [P-1:0] pdata [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; next_free = 0; acc_cyc = -100; acc_id = 0; exp_done_id = 0;
    rr_m = 0; acc_data = '0;
  endtask

  task automatic tick();
    int w;
    int pos;
    logic [N-1:0] exp_ready;
    if (cyc == acc_cyc + F + 1) exp_done_id = acc_id;
    chk("tx_start", 32'(tx_start), 32'(cyc == acc_cyc + 1));
    chk("tx_data",  32'(tx_data),  32'(acc_data));
    chk("grant_id", 32'(grant_id), 32'(acc_id));
    chk("busy",     32'(busy),     32'(cyc < next_free));
    chk("tx_done",  32'(tx_done),  32'(cyc == acc_cyc + F + 1));
    chk("done_id",  32'(done_id),  32'(exp_done_id));
    req_valid = pend;
    for (int i = 0; i < N; i++) req_data[i*P +: P] = pdata[i];
    #1;
    w = -1;
    exp_ready = '0;
    if (cyc >= next_free) begin
      for (int k = 0; k < N; k++) begin
        pos = (rr_m + k) % N;
        if (w < 0 && pend[pos]) w = pos;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (w >= 0) begin
      acc_cyc   = cyc;
      acc_id    = w;
      acc_data  = pdata[w];
      rr_m      = (w + 1) % N;
      next_free = cyc + F + G + 1;
      pend[w]   = 1'b0;
      n_accepts++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic tick_until_accept(input string tag);
    int n0;
    n0 = n_accepts;
    for (int t = 0; t < 40 && n_accepts == n0; t++) tick();
    chk(tag, 32'(n_accepts > n0), 32'd1);
  endtask

  initial begin
    int n0, prev_acc, gap0_t;
    int starts[$];
    rst = 1'b0;
    req_valid = '0; req_data = '0; pend = '0; n_accepts = 0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    req_valid2 = '1;
    for (int i = 0; i < N; i++) req_data2[i*P +: P] = 8'(8'h40 + i);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Idle with nothing pending, then a single request from requester 2.
    repeat (3) tick();
    pend[2] = 1'b1; pdata[2] = 8'hA5;
    tick_until_accept("single_accept");
    chk("single_winner", 32'(acc_id), 32'd2);
    repeat (16) tick();

    // All requesters continuously pending: accepts spaced one frame period apart.
    prev_acc = -1;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1'b1; pdata[i] = 8'(8'h10 + i); end
      n0 = n_accepts;
      tick();
      if (n_accepts != n0) begin
        if (prev_acc >= 0) chk("accept_spacing", 32'(acc_cyc - prev_acc), 32'(F + G + 1));
        prev_acc = acc_cyc;
      end
    end
    pend = '0;
    repeat (15) tick();

    // Request raised mid-frame and withdrawn during the gap is never accepted.
    pend[3] = 1'b1; pdata[3] = 8'h3C;
    tick_until_accept("wd_first_accept");
    repeat (3) tick();
    pend[1] = 1'b1; pdata[1] = 8'h77;
    for (int t = 0; t < 20 && cyc < next_free - 1; t++) tick();
    pend[1] = 1'b0;
    n0 = n_accepts;
    repeat (4) tick();
    chk("withdraw_no_accept", 32'(n_accepts), 32'(n0));

    // Randomized producers with random withdrawal.
    for (int t = 0; t < 700; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; pdata[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 24) == 0) begin
          pend[i] = 1'b0;
        end
      end
      tick();
    end
    pend = '0;
    repeat (15) tick();

    // Reset in the fifth SEND cycle aborts the frame.
    pend[1] = 1'b1; pdata[1] = 8'hC3;
    tick_until_accept("rst_pre_accept");
    repeat (4) tick();
    #1 rst = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_done",  32'(tx_done),  32'd0);
    chk("rst_done_id",  32'(done_id),  32'd0);
    chk("rst_ready",    32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    pend = '1;
    for (int i = 0; i < N; i++) pdata[i] = 8'(8'h20 + i);
    tick();
    chk("post_rst_grant0", 32'(acc_id), 32'd0);
    repeat (14) tick();

    // Zero-gap instance: 12-cycle accept spacing, tx_done lands on the IDLE cycle.
    gap0_t = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      gap0_t++;
      if (tx_start2) starts.push_back(gap0_t);
      if (tx_done2) chk("gap0_done_idle", 32'((|req_ready2) && !busy2), 32'd1);
    end
    chk("gap0_starts_seen", 32'(starts.size() >= 2), 32'd1);
    if (starts.size() >= 2) chk("gap0_spacing", 32'(starts[1] - starts[0]), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
